// File: rtl/gcd_controller.sv
// Moore FSM controller for a subtract-based GCD datapath (A/B registers, subtractor, compare flags).
// Optional iteration timeout enabled by defining GCD_TIMEOUT_EN.
module gcd_controller #(
  parameter logic [15:0] MAX_ITER = 16'd1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  output logic sel1,
  output logic sel2,
  output logic sel3,
  output logic sel4,
  output logic load_A,
  output logic load_B,
  output logic done,
  output logic busy,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_CMP,
    S_SUB_A,
    S_SUB_B,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic   timeout;
  logic   err_flag;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

`ifdef GCD_TIMEOUT_EN
  logic [15:0] iter_cnt;

  // Only consulted in S_CMP; a converged pair (eq) always wins over the limit.
  assign timeout = (iter_cnt == MAX_ITER) && !eq;

  always_ff @(posedge clk) begin
    if (!rst) begin
      iter_cnt <= 16'd0;
      err_flag <= 1'b0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      iter_cnt <= 16'd0;
      err_flag <= 1'b0;
    end else if (state == S_CMP) begin
      if (timeout) begin
        err_flag <= 1'b1;
      end else if ((state_next == S_SUB_A || state_next == S_SUB_B) &&
                   iter_cnt != 16'hFFFF) begin
        iter_cnt <= iter_cnt + 16'd1;
      end
    end
  end
`else
  logic unused_max_iter;

  assign timeout         = 1'b0;
  assign err_flag        = 1'b0;
  assign unused_max_iter = ^MAX_ITER;
`endif

  always_comb begin
    state_next = state;
    sel1       = 1'b0;
    sel2       = 1'b0;
    sel3       = 1'b0;
    sel4       = 1'b0;
    load_A     = 1'b0;
    load_B     = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    err        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LOAD_A;
      end
      S_LOAD_A: begin
        sel1       = 1'b1;
        load_A     = 1'b1;
        busy       = 1'b1;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        sel2       = 1'b1;
        load_B     = 1'b1;
        busy       = 1'b1;
        state_next = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        // No flag set is an illegal compare result; terminate rather than spin.
        if (timeout)  state_next = S_DONE;
        else if (eq)  state_next = S_DONE;
        else if (gt)  state_next = S_SUB_A;
        else if (lt)  state_next = S_SUB_B;
        else          state_next = S_DONE;
      end
      S_SUB_A: begin
        sel3       = 1'b1;
        load_A     = 1'b1;
        busy       = 1'b1;
        state_next = S_CMP;
      end
      S_SUB_B: begin
        sel4       = 1'b1;
        load_B     = 1'b1;
        busy       = 1'b1;
        state_next = S_CMP;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_flag;
        if (start) state_next = S_LOAD_A;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller driving a behavioural GCD datapath model.
// Results and latencies are hand-computed; all comparisons happen in the monitor process.
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        lt, gt, eq;
  logic        sel1, sel2, sel3, sel4, load_A, load_B, done, busy, err;
  logic [15:0] inp = 16'd0;
  logic [15:0] a_reg = 16'd0;
  logic [15:0] b_reg = 16'd0;
  logic [15:0] diff;

  gcd_controller #(.MAX_ITER(16'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .lt(lt), .gt(gt), .eq(eq),
    .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4),
    .load_A(load_A), .load_B(load_B), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Datapath model: mux, subtractor, A/B registers, comparator.
  assign diff = (sel3 ? a_reg : b_reg) - (sel4 ? a_reg : b_reg);
  assign lt   = a_reg < b_reg;
  assign gt   = a_reg > b_reg;
  assign eq   = a_reg == b_reg;

  always @(posedge clk) begin
    if (load_A) a_reg <= sel1 ? inp : diff;
    if (load_B) b_reg <= sel2 ? inp : diff;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] g;
    int          lat;
    logic        e;
  } exp_t;

  typedef struct {
    int         kind;
    logic [8:0] val;
    logic [8:0] mask;
  } snap_t;

  localparam int K_SNAP = 0;
  localparam int K_TIMEOUT = 1;
  localparam int K_DRAIN = 2;

  exp_t  sb[$];
  snap_t snap_q[$];
  int    start_cyc = 0;
  int    done_seen = 0;
  logic  done_q = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: result scoreboard, step-rule invariants, and posted snapshots.
  always @(negedge clk) begin
    exp_t  e;
    snap_t s;
    done_q <= done;
    if (done && !done_q) begin
      done_seen <= done_seen + 1;
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("outp", {16'd0, a_reg}, {16'd0, e.g});
        chk("latency", cyc - start_cyc, e.lat);
        chk("err_at_done", {31'd0, err}, {31'd0, e.e});
      end
    end
    if (load_A && !sel1) chk("sub_a_selects", {30'd0, sel3, sel4}, 32'd2);
    if (load_B && !sel2) chk("sub_b_selects", {30'd0, sel3, sel4}, 32'd1);
    while (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      case (s.kind)
        K_SNAP: chk("outputs", {23'd0, {sel1, sel2, sel3, sel4, load_A, load_B, done, busy, err} & s.mask},
                    {23'd0, s.val & s.mask});
        K_TIMEOUT: chk("done_timeout", 32'd1, 32'd0);
        default: chk("scoreboard_empty", sb.size(), 32'd0);
      endcase
    end
  end

  task automatic post(input int kind, input logic [8:0] val, input logic [8:0] mask);
    snap_t s;
    s.kind = kind;
    s.val  = val;
    s.mask = mask;
    snap_q.push_back(s);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                       input int n, input logic e, input bit poke);
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    x.g   = g;
    x.lat = 3 + 2 * n;
    x.e   = e;
    sb.push_back(x);
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    inp   = a;
    @(negedge clk);
    inp = b;
    @(negedge clk);
    inp = 16'hDEAD;
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 300; k++) begin
      if (done_seen >= target) break;
      @(negedge clk);
    end
    if (done_seen < target) post(K_TIMEOUT, 9'd0, 9'd0);
  endtask

  initial begin
    int ops;
    ops = 0;
    repeat (3) @(posedge clk);
    #1 post(K_SNAP, 9'd0, 9'h1FF);
    @(negedge clk);
    rst = 1'b1;

    do_op(16'd12, 16'd12, 16'd12, 0, 1'b0, 1'b0); ops++; wait_done(ops);
    do_op(16'd12, 16'd8, 16'd4, 2, 1'b0, 1'b0);   ops++; wait_done(ops);
    // 48,18 -> 30,18 -> 12,18 -> 12,6 -> 6,6 : four subtractions; start pokes mid-run.
    do_op(16'd48, 16'd18, 16'd6, 4, 1'b0, 1'b1);  ops++; wait_done(ops);
    do_op(16'd7, 16'd3, 16'd1, 4, 1'b0, 1'b0);    ops++; wait_done(ops);

    // Reset in the middle of S_SUB_A.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inp   = 16'd100;
    @(negedge clk);
    inp = 16'd3;
    @(posedge clk);
    @(posedge clk);
    #1 post(K_SNAP, 9'b001010010, 9'h1FF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 post(K_SNAP, 9'd0, 9'h1FF);

    // start coincident with reset must be dropped.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 post(K_SNAP, 9'd0, 9'h1FF);

    do_op(16'd9, 16'd6, 16'd3, 2, 1'b0, 1'b0); ops++; wait_done(ops);

`ifdef GCD_TIMEOUT_EN
    do_op(16'd0, 16'd5, 16'd0, 4, 1'b1, 1'b0); ops++; wait_done(ops);
`else
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    inp   = 16'd0;
    @(negedge clk);
    inp = 16'd5;
    repeat (100) @(posedge clk);
    #1 post(K_SNAP, 9'b000000010, 9'b000000111);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`endif

    @(negedge clk);
    post(K_DRAIN, 9'd0, 9'd0);
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
